// File: rtl/alu_sequencer_pkg.sv
// alu_seq_pkg: opcodes, sequencer states and shared constants for alu_sequencer
package alu_seq_pkg;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_XOR = 3'd2;
  localparam logic [2:0] OP_SLT = 3'd3;
  localparam logic [2:0] OP_MUL = 3'd4;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  typedef enum logic [3:0] {
    IDLE, EVAL, MUL_SIGN, MUL_NEG_A, MUL_NEG_B, MUL_SCAN, MUL_ADD, MUL_NEG_P, DONE
  } state_t;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request and result handshake between the core and the sequencer
interface alu_sequencer_if;
  logic op_valid, op_ready;
  logic [2:0] op_code;
  logic [31:0] op_a, op_b;
  logic res_valid, res_ready;
  logic [31:0] res_data;
  logic res_zero, res_overflow, res_cout;
  modport master (
    output op_valid, op_code, op_a, op_b, res_ready,
    input op_ready, res_valid, res_data, res_zero, res_overflow, res_cout
  );
  modport slave (
    input op_valid, op_code, op_a, op_b, res_ready,
    output op_ready, res_valid, res_data, res_zero, res_overflow, res_cout
  );
endinterface

// File: rtl/alu_sequencer_timer.sv
// alu_settle_timer: counts the ALU settle window, done marks its last cycle
module alu_settle_timer #(parameter int SETTLE_CYCLES = 4) (
  input logic clk,
  input logic rst_n,
  input logic start,
  output logic done
);
  logic [3:0] cnt;
  logic busy;
  assign done = busy && cnt == 4'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      busy <= 1'b0;
    end else if (start) begin
      cnt <= 4'(SETTLE_CYCLES - 1);
      busy <= 1'b1;
    end else if (busy) begin
      busy <= cnt != 4'd0;
      cnt <= cnt - 4'd1;
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: drives an external ALU through a settle window; builds signed MUL
// from a shift-add scan of |b| using ALU ADD/SUB evaluations.
module alu_sequencer import alu_seq_pkg::*; #(parameter int SETTLE_CYCLES = 4) (
  input logic clk,
  input logic rst_n,
  alu_sequencer_if.slave bus,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0] alu_ctrl,
  input logic [31:0] alu_out,
  input logic alu_zero,
  input logic alu_overflow,
  input logic alu_cout
);
  state_t state;
  logic [31:0] ma, mb, acc, ma_cur, mb_cur, acc_cur;
  logic [4:0] idx;
  logic [5:0] nidx;
  logic sb, neg, ovf, start, done, first, last, nbit, adv, ovf_add, ovf_fin;
  alu_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (.clk, .rst_n, .start, .done);
  // Values as they will be once this edge's capture lands, so the next bit can start immediately
  assign ma_cur = state == MUL_NEG_A ? alu_out : ma;
  assign mb_cur = state == MUL_NEG_B ? alu_out : mb;
  assign acc_cur = state == MUL_ADD ? alu_out : acc;
  assign first = state == MUL_SIGN || state == MUL_NEG_A || state == MUL_NEG_B;
  assign nidx = first ? 6'd0 : {1'b0, idx} + 6'd1;
  assign last = !first && idx == 5'd31;
  assign nbit = mb_cur[nidx[4:0]];
  assign adv = (state == MUL_SIGN && !ma[31] && !mb[31]) || (state == MUL_NEG_A && done && !sb) ||
               (state == MUL_NEG_B && done) || state == MUL_SCAN || (state == MUL_ADD && done);
  assign ovf_add = ovf || (state == MUL_ADD && alu_cout);
  assign ovf_fin = ovf_add || acc_cur > (neg ? INT_MIN : INT_MIN - 32'd1);
  assign start = (state == IDLE && bus.op_valid && bus.op_code < OP_MUL) ||
                 (state == MUL_SIGN && (ma[31] || mb[31])) || (state == MUL_NEG_A && done && sb) ||
                 (adv && (last ? neg : nbit));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      bus.op_ready <= 1'b1;
      bus.res_valid <= 1'b0;
      bus.res_data <= '0;
      bus.res_zero <= 1'b0;
      bus.res_overflow <= 1'b0;
      bus.res_cout <= 1'b0;
      alu_a <= '0;
      alu_b <= '0;
      alu_ctrl <= OP_ADD;
      ma <= '0;
      mb <= '0;
      acc <= '0;
      idx <= '0;
      sb <= 1'b0;
      neg <= 1'b0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.op_valid) begin
          bus.op_ready <= 1'b0;
          ma <= bus.op_a;
          mb <= bus.op_b;
          acc <= '0;
          ovf <= 1'b0;
          if (bus.op_code < OP_MUL) begin
            alu_a <= bus.op_a;
            alu_b <= bus.op_b;
            alu_ctrl <= bus.op_code;
            state <= EVAL;
          end else if (bus.op_code == OP_MUL) state <= MUL_SIGN;
          else begin
            bus.res_data <= '0;
            bus.res_zero <= 1'b1;
            bus.res_overflow <= 1'b0;
            bus.res_cout <= 1'b0;
            bus.res_valid <= 1'b1;
            state <= DONE;
          end
        end
        EVAL: if (done) begin
          bus.res_data <= alu_out;
          bus.res_zero <= alu_zero;
          bus.res_overflow <= alu_overflow;
          bus.res_cout <= alu_cout;
          bus.res_valid <= 1'b1;
          state <= DONE;
        end
        MUL_SIGN: begin
          sb <= mb[31];
          neg <= ma[31] ^ mb[31];
          alu_a <= ma[31] || mb[31] ? 32'd0 : alu_a;
          alu_b <= ma[31] ? ma : mb[31] ? mb : alu_b;
          alu_ctrl <= ma[31] || mb[31] ? OP_SUB : alu_ctrl;
          state <= ma[31] ? MUL_NEG_A : mb[31] ? MUL_NEG_B : state;
        end
        MUL_NEG_A: if (done) begin
          ma <= alu_out;
          if (sb) begin
            alu_b <= mb;
            state <= MUL_NEG_B;
          end
        end
        MUL_NEG_B: if (done) mb <= alu_out;
        MUL_NEG_P: if (done) begin
          bus.res_data <= alu_out;
          bus.res_zero <= alu_out == 32'd0;
          bus.res_overflow <= ovf;
          bus.res_cout <= 1'b0;
          bus.res_valid <= 1'b1;
          state <= DONE;
        end
        DONE: if (bus.res_ready) begin
          bus.res_valid <= 1'b0;
          bus.op_ready <= 1'b1;
          state <= IDLE;
        end
        default: ;
      endcase
      // Step to the next bit of |b|, or finish the product after bit 31
      if (adv) begin
        acc <= acc_cur;
        if (last) begin
          ovf <= ovf_fin;
          if (neg) begin
            alu_a <= '0;
            alu_b <= acc_cur;
            alu_ctrl <= OP_SUB;
            state <= MUL_NEG_P;
          end else begin
            bus.res_data <= acc_cur;
            bus.res_zero <= acc_cur == 32'd0;
            bus.res_overflow <= ovf_fin;
            bus.res_cout <= 1'b0;
            bus.res_valid <= 1'b1;
            state <= DONE;
          end
        end else begin
          idx <= nidx[4:0];
          ovf <= ovf_add || (nbit && |(ma_cur >> (6'd32 - nidx)));
          if (nbit) begin
            alu_a <= acc_cur;
            alu_b <= ma_cur << nidx;
            alu_ctrl <= OP_ADD;
            state <= MUL_ADD;
          end else state <= MUL_SCAN;
        end
      end
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle controller that owns the 32-bit MIPS-style ALU (ADD/SUB/XOR/SLT) and exposes it to the core through a valid/ready request and result interface. It drives the ALU's A, B and Ctrl inputs, holds them stable for a programmable settle window, and captures the result and flags. It also implements MUL (opcode 100), which the ALU lacks, as a signed shift-add sequence built from ALU ADD and SUB evaluations.

## Interface
Parameters:
- SETTLE_CYCLES, default 4: clock cycles that ALU inputs are held before its outputs are sampled; legal range 1..15.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_valid  in  1  request present.
- op_ready  out  1  sequencer idle and accepting; reset 1.
- op_code  in  3  000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 MUL, 101–111 illegal.
- op_a, op_b  in  32  operands; sampled on the accept edge only.
- res_valid  out  1  result held; reset 0.
- res_ready  in  1  consumer takes result.
- res_data  out  32  result; reset 0.
- res_zero, res_overflow, res_cout  out  1 each  flags; reset 0.
- alu_a, alu_b  out  32  to ALU; reset 0.
- alu_ctrl  out  3  to ALU; reset 000.
- alu_out  in  32  from ALU.
- alu_zero, alu_overflow, alu_cout  in  1 each  from ALU.

## Operation
- States: IDLE, EVAL, MUL_SIGN, MUL_NEG_A, MUL_NEG_B, MUL_SCAN, MUL_ADD, MUL_NEG_P, DONE.
- IDLE: op_ready=1. Accept on op_valid&&op_ready. ADD/SUB/XOR/SLT go to EVAL. MUL goes to MUL_SIGN. Illegal codes go directly to DONE with res_data=0, res_zero=1, other flags 0.
- EVAL: alu_a=op_a, alu_b=op_b, alu_ctrl=op_code, held for SETTLE_CYCLES. On the last cycle, alu_out and the three flags are captured; res_zero is taken from alu_zero. Then DONE.
- MUL_SIGN (1 cycle): record sa=a[31], sb=b[31], neg=sa^sb. Then go to MUL_NEG_A if sa, else MUL_NEG_B if sb, else MUL_SCAN.
- MUL_NEG_A / MUL_NEG_B: ALU SUB with alu_a=0 and alu_b=operand; the captured alu_out becomes the magnitude. Takes SETTLE_CYCLES. 0x80000000 maps to itself and is treated as unsigned 2^31.
- MUL_SCAN: examine one bit i (0..31) of |b| per cycle.
  - Bit 0: advance, 1 cycle.
  - Bit 1: MUL_ADD with alu_ctrl=000, alu_a=acc, alu_b=|a|<<i; acc takes alu_out after SETTLE_CYCLES.
  - acc starts at 0.
- Overflow sticky bit ovf is set by:
  - any MUL_ADD capture with alu_cout=1;
  - any set bit i>0 with (|a|>>(32-i))!=0;
  - after the scan, acc>0x7FFFFFFF when neg=0;
  - after the scan, acc>0x80000000 when neg=1.
- MUL_NEG_P: entered only when neg=1. acc = 0−acc via ALU SUB.
- MUL result: res_data = low 32 bits of the signed product (correct even when ovf=1), res_overflow=ovf, res_zero=(res_data==0), res_cout=0.
- DONE: res_valid=1 and all res_* held stable until res_ready. Then go to IDLE, where res_valid=0 and res_* keep their values.
- No pipelining: op_ready is 0 from the accept edge until DONE exits.
- alu_a, alu_b and alu_ctrl change only on the cycle an ALU evaluation starts. They hold their last values otherwise.

## Timing
- Cycle 0 is the accept edge.
- ADD/SUB/XOR/SLT: res_valid first high in cycle SETTLE_CYCLES+1.
- Illegal opcode: res_valid in cycle 1.
- MUL: res_valid first high in cycle 2 + S·(n_neg + p) + (32 − p), where S=SETTLE_CYCLES, p=popcount(|b|), and n_neg = sa + sb + neg (0..3).
- Back-to-back: next accept is no earlier than the cycle after the res handshake.
- Reset is asserted asynchronously and takes effect mid-operation. All outputs go to their reset values at once, the operation is dropped, and no res_valid is produced. Deassertion is sampled on clk.
- op_valid while busy is ignored, with no queueing.

## Structure
- Package alu_seq_pkg holds:
  - opcode localparams (OP_ADD..OP_MUL);
  - the state enum;
  - the constant for 0x80000000.
- One sub-module, alu_settle_timer: a 4-bit down-counter loaded with SETTLE_CYCLES−1 on start, with a `done` pulse on its last cycle. It is reused by EVAL and all MUL ALU states.

## Test plan
- ADD 2+5, S=4 → res_data=7, res_zero=0, res_valid first in cycle 5, alu_* stable in cycles 1–4.
- SUB 2000000000 − (−2000000000) → res_overflow=1. SLT 2,9 → res_data=1. SLT 10,10 → res_data=0 and res_zero=1.
- MUL 2·5, S=4 → res_data=10, res_overflow=0, res_valid first in cycle 40. MUL 6·(−3) → res_data=0xFFFFFFEE, res_overflow=0.
- MUL 200000·200000 → res_data=0x502F9000, res_overflow=1. MUL 0x80000000·1 → res_data=0x80000000, res_overflow=0.
- Backpressure: hold res_ready=0 for 10 cycles after res_valid → res_* unchanged, op_ready=0, and a new op_valid is not accepted.
- Assert rst_n low mid-MUL (during MUL_ADD) → all outputs reset immediately. After release, ADD 10+(−10) → res_data=0, res_zero=1.
